// File: rtl/serial_seq_gen.sv
// Serial pattern transmitter: parallel word in over valid/ready, MSB-first bit stream out.
// Optional MATCH_CNT_EN adds an overlapping PATTERN match counter on the emitted stream.
module serial_seq_gen #(
   parameter int WIDTH   = 8,
   parameter int GAP_CYC = 2
`ifdef MATCH_CNT_EN
   ,
   parameter int                 PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PATTERN = 4'b1010,
   parameter int                 CNT_W   = 8
`endif
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   output logic             load_ready,
   output logic             bit_out,
   output logic             bit_valid,
   output logic             last,
   output logic             busy
`ifdef MATCH_CNT_EN
   ,
   output logic [CNT_W-1:0] match_cnt
`endif
);

   localparam int BW = $clog2(WIDTH);
   localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      GAP
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [BW-1:0]    bcnt;
   logic [GW-1:0]    gcnt;
   logic             take;

   // Reload is only possible in the LSB cycle when no gap is configured.
   assign load_ready = (state == IDLE)
                     | ((state == SHIFT) & last & (GAP_CYC == 0));
   assign take = load_valid & load_ready;
   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         shreg     <= '0;
         bcnt      <= '0;
         gcnt      <= '0;
         bit_out   <= 1'b0;
         bit_valid <= 1'b0;
         last      <= 1'b0;
      end else if (take) begin
         state     <= SHIFT;
         bit_out   <= load_data[WIDTH-1];
         bit_valid <= 1'b1;
         last      <= 1'b0;
         shreg     <= {load_data[WIDTH-2:0], 1'b0};
         bcnt      <= BW'(1);
      end else begin
         unique case (state)
            IDLE: begin
               bit_out   <= 1'b0;
               bit_valid <= 1'b0;
               last      <= 1'b0;
            end
            SHIFT: begin
               if (!last) begin
                  bit_out <= shreg[WIDTH-1];
                  shreg   <= {shreg[WIDTH-2:0], 1'b0};
                  bcnt    <= bcnt + BW'(1);
                  last    <= (bcnt == BW'(WIDTH - 1));
               end else begin
                  bit_out   <= 1'b0;
                  bit_valid <= 1'b0;
                  last      <= 1'b0;
                  gcnt      <= '0;
                  if (GAP_CYC > 0) begin
                     state <= GAP;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            GAP: begin
               if (gcnt == GW'(GAP_CYC - 1)) begin
                  state <= IDLE;
               end else begin
                  gcnt <= gcnt + GW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MATCH_CNT_EN
   localparam int HW = PAT_LEN - 1;
   localparam int FW = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;

   // hist plus the live bit_out forms the PAT_LEN-bit window.
   logic [HW-1:0] hist;
   logic [FW-1:0] fill;
   logic          hit;

   assign hit = bit_valid
              & (fill == FW'(HW))
              & ({hist, bit_out} == PATTERN);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hist      <= '0;
         fill      <= '0;
         match_cnt <= '0;
      end else if (!bit_valid) begin
         hist <= '0;
         fill <= '0;
      end else begin
         hist <= HW'({hist, bit_out});
         if (fill != FW'(HW)) begin
            fill <= fill + FW'(1);
         end
         if (hit && (match_cnt != '1)) begin
            match_cnt <= match_cnt + CNT_W'(1);
         end
      end
   end
`endif

endmodule
